// File: rtl/multi_debouncer.sv
// Per-channel debouncer: 2-flop synchronizer, then a counter that must see CYCLES+1 stable matching
// samples before committing. Levels and pulses move together CYCLES+2 edges after a clean step.
module multi_debouncer #(
  parameter int                  CHANNELS      = 4,
  parameter int                  CYCLES        = 10,
  parameter int                  COUNTER_WIDTH = 32,
  parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] bouncy,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  localparam logic [COUNTER_WIDTH-1:0] CYC_MAX = COUNTER_WIDTH'(CYCLES);

  // Declaration initialisers give power-up state equal to the reset state.
  logic [CHANNELS-1:0]                    s0_q      = RESET_VALUE;
  logic [CHANNELS-1:0]                    s1_q      = RESET_VALUE;
  logic [CHANNELS-1:0]                    deb_q     = RESET_VALUE;
  logic [CHANNELS-1:0][COUNTER_WIDTH-1:0] cnt_q     = '0;
  logic [CHANNELS-1:0]                    rise_q    = '0;
  logic [CHANNELS-1:0]                    fall_q    = '0;
  logic                                   changed_q = 1'b0;

  logic [CHANNELS-1:0]                    deb_d;
  logic [CHANNELS-1:0][COUNTER_WIDTH-1:0] cnt_d;
  logic [CHANNELS-1:0]                    rise_d;
  logic [CHANNELS-1:0]                    fall_d;

  always_comb begin
    deb_d  = deb_q;
    cnt_d  = '0;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      // Count only while the synchronized input is steady and differs from the committed level.
      if ((s0_q[i] == s1_q[i]) && (s1_q[i] != deb_q[i])) begin
        if (cnt_q[i] == CYC_MAX) begin
          deb_d[i]  = s1_q[i];
          rise_d[i] = s1_q[i];
          fall_d[i] = ~s1_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + COUNTER_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_q      <= RESET_VALUE;
      s1_q      <= RESET_VALUE;
      deb_q     <= RESET_VALUE;
      cnt_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      s0_q      <= bouncy;
      s1_q      <= s0_q;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= |(rise_d | fall_d);
    end
  end

  assign debounced = deb_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign changed   = changed_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed vector table, hand-written corner sequences and random
// stimulus, all checked against a run-length model of the debounce rule.
module tb_multi_debouncer;

  localparam int         CYC  = 4;
  localparam logic [3:0] RV_A = 4'b0000;
  localparam logic [3:0] RV_B = 4'b1010;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic [3:0] bouncy_a = RV_A;
  logic [3:0] bouncy_b = RV_B;
  logic [3:0] deb_a, rise_a, fall_a, deb_b, rise_b, fall_b;
  logic       chg_a, chg_b;

  always #5 clk = ~clk;

  multi_debouncer #(.CHANNELS(4), .CYCLES(CYC), .COUNTER_WIDTH(3), .RESET_VALUE(RV_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bouncy(bouncy_a),
    .debounced(deb_a), .rise(rise_a), .fall(fall_a), .changed(chg_a));

  multi_debouncer #(.CHANNELS(4), .CYCLES(CYC), .COUNTER_WIDTH(32), .RESET_VALUE(RV_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bouncy(bouncy_b),
    .debounced(deb_b), .rise(rise_b), .fall(fall_b), .changed(chg_b));

  int checks = 0;
  int errors = 0;

  // Model: a level commits once the last CYC+2 input samples all agree and differ from it.
  logic [3:0] m_deb [2];
  logic [3:0] m_rise[2];
  logic [3:0] m_fall[2];
  logic       m_chg [2];
  logic       run_val[2][4];
  int         run_len[2][4];

  typedef struct {
    logic       rst;
    logic [3:0] b;
    logic [3:0] deb;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       chg;
  } vec_t;
  vec_t tbl[$];

  logic [3:0] sticky_b = 4'b0;
  logic [3:0] fall_or, rise_or;
  int         rise_cnt, rise_at, fall_at, idx, prob;
  int         probs[3] = '{2, 8, 32};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_init(input int d, input logic [3:0] rv);
    m_deb[d]  = rv;
    m_rise[d] = 4'b0;
    m_fall[d] = 4'b0;
    m_chg[d]  = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      run_val[d][ch] = rv[ch];
      run_len[d][ch] = 2;
    end
  endfunction

  function automatic void model_edge(input int d, input logic rst, input logic [3:0] b,
                                     input logic [3:0] rv);
    if (!rst) begin
      model_init(d, rv);
      return;
    end
    m_rise[d] = 4'b0;
    m_fall[d] = 4'b0;
    for (int ch = 0; ch < 4; ch++) begin
      if ((run_val[d][ch] != m_deb[d][ch]) && (run_len[d][ch] >= CYC + 2)) begin
        m_deb[d][ch] = run_val[d][ch];
        if (run_val[d][ch]) m_rise[d][ch] = 1'b1;
        else                m_fall[d][ch] = 1'b1;
      end
      if (b[ch] == run_val[d][ch]) begin
        if (run_len[d][ch] < CYC + 2) run_len[d][ch]++;
      end else begin
        run_val[d][ch] = b[ch];
        run_len[d][ch] = 1;
      end
    end
    m_chg[d] = |(m_rise[d] | m_fall[d]);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge(0, rst_n, bouncy_a, RV_A);
    model_edge(1, rst_n, bouncy_b, RV_B);
    #1;
    chk("a_debounced", 32'(deb_a),  32'(m_deb[0]));
    chk("a_rise",      32'(rise_a), 32'(m_rise[0]));
    chk("a_fall",      32'(fall_a), 32'(m_fall[0]));
    chk("a_changed",   32'(chg_a),  32'(m_chg[0]));
    chk("b_debounced", 32'(deb_b),  32'(m_deb[1]));
    chk("b_rise",      32'(rise_b), 32'(m_rise[1]));
    chk("b_fall",      32'(fall_b), 32'(m_fall[1]));
    chk("b_changed",   32'(chg_b),  32'(m_chg[1]));
    sticky_b |= rise_b | fall_b | {3'b000, chg_b};
  endtask

  function automatic void add(input int n, input logic rst, input logic [3:0] b,
                              input logic [3:0] deb, input logic [3:0] rise,
                              input logic [3:0] fall, input logic chg);
    vec_t v;
    v.rst = rst; v.b = b; v.deb = deb; v.rise = rise; v.fall = fall; v.chg = chg;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  initial begin
    add(1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(6, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);  // clean step on ch0
    add(1, 1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    add(1, 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add(3, 1'b1, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b0);  // 3-cycle glitch on ch1
    add(8, 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add(6, 1'b1, 4'b1001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add(1, 1'b1, 4'b1001, 4'b1001, 4'b1000, 4'b0000, 1'b1);
    add(1, 1'b1, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 1'b0);
    add(6, 1'b1, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 1'b0);  // ch0 and ch3 fall together
    add(1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 1'b1);
    add(1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(5, 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0);  // ch2 counts to 3, then reset
    add(1, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(6, 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(1, 1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b1);
    add(1, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0);

    model_init(0, RV_A);
    model_init(1, RV_B);
    #1;
    chk("powerup_a_debounced", 32'(deb_a), 32'(RV_A));
    chk("powerup_b_debounced", 32'(deb_b), 32'(RV_B));
    chk("powerup_a_pulses", 32'(rise_a | fall_a), 32'd0);
    chk("powerup_b_changed", 32'(chg_b), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n    = tbl[i].rst;
      bouncy_a = tbl[i].b;
      step();
      chk($sformatf("vec%0d_debounced", i), 32'(deb_a),  32'(tbl[i].deb));
      chk($sformatf("vec%0d_rise", i),      32'(rise_a), 32'(tbl[i].rise));
      chk($sformatf("vec%0d_fall", i),      32'(fall_a), 32'(tbl[i].fall));
      chk($sformatf("vec%0d_changed", i),   32'(chg_a),  32'(tbl[i].chg));
    end
    rst_n = 1'b1;

    // Bounce train on ch2: toggles every 2 cycles, then settles high.
    bouncy_a = 4'b0000;
    repeat (8) step();
    chk("train_start_level", 32'(deb_a), 32'd0);
    rise_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      bouncy_a = ((k % 4) < 2) ? 4'b0100 : 4'b0000;
      step();
      rise_cnt += int'(rise_a[2]);
    end
    chk("train_no_early_rise", 32'(rise_cnt), 32'd0);
    bouncy_a = 4'b0100;
    rise_at  = -1;
    for (int k = 0; k < 15; k++) begin
      step();
      if (rise_a[2]) begin
        rise_cnt++;
        if (rise_at < 0) rise_at = k;
      end
    end
    chk("train_rise_edge", 32'(rise_at), 32'(CYC + 2));
    chk("train_rise_count", 32'(rise_cnt), 32'd1);
    chk("train_level", 32'(deb_a), 32'b0100);

    // Non-zero reset value: holding the reset pattern never pulses; clearing it falls bits 1 and 3.
    chk("b_hold_no_pulse", 32'(sticky_b), 32'd0);
    bouncy_b = 4'b0000;
    fall_or  = 4'b0;
    rise_or  = 4'b0;
    fall_at  = -1;
    for (int k = 0; k < 10; k++) begin
      step();
      fall_or |= fall_b;
      rise_or |= rise_b;
      if ((fall_b != 4'b0) && (fall_at < 0)) fall_at = k;
    end
    chk("b_fall_bits", 32'(fall_or), 32'b1010);
    chk("b_no_rise", 32'(rise_or), 32'd0);
    chk("b_fall_edge", 32'(fall_at), 32'(CYC + 2));
    chk("b_final_level", 32'(deb_b), 32'd0);

    for (int blk = 0; blk < 15; blk++) begin
      prob = probs[blk % 3];
      repeat (100) begin
        if ($urandom_range(prob - 1, 0) == 0) begin
          idx = $urandom_range(3, 0);
          bouncy_a[idx] = ~bouncy_a[idx];
        end
        if ($urandom_range(prob - 1, 0) == 0) begin
          idx = $urandom_range(3, 0);
          bouncy_b[idx] = ~bouncy_b[idx];
        end
        rst_n = ($urandom_range(299, 0) != 0);
        step();
      end
    end
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
